// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix result path.
// Defaults match the standard 4x4, 16-bit multiplier build.
package matrix_pkg;

  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 16;

  typedef logic [2*WIDTH_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM
  } drain_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Wait counter only needs to hold LATENCY-1
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  localparam int IDX_W = idx_w(N_DEF);

endpackage

// File: rtl/matrix_idx_counter.sv
// Row-major (row, col) walker over an NxN array.
// Synchronous clear has priority over advance.
module matrix_idx_counter
  import matrix_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] row_o,
  output logic [IW-1:0] col_o,
  output logic          last_o
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == MAX) begin
        col_d = '0;
        row_d = (row_q == MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/matrix_result_drain.sv
// Snapshots the multiplier result LATENCY cycles after start and
// streams it row-major over valid/ready while the multiplier moves on.
module matrix_result_drain
  import matrix_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int PIPE_STAGES = 2,
  parameter int LATENCY     = PIPE_STAGES + N + 1,
  localparam int EW = 2 * WIDTH,
  localparam int IW = idx_w(N),
  localparam int CW = cnt_w(LATENCY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW-1:0] C [N][N],
  output logic          busy,
  output logic [EW-1:0] out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);

  drain_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          done_q;
  logic [EW-1:0] shadow_q [N][N];

  logic          capture;
  logic          hs;
  logic          last;
  logic [IW-1:0] row;
  logic [IW-1:0] col;

  assign capture = (state_q == WAIT) && (cnt_q == '0);
  assign hs      = valid_q && out_ready;

  matrix_idx_counter #(.N(N)) u_idx (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (capture),
    .en_i   (hs),
    .row_o  (row),
    .col_o  (col),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT;
            cnt_q   <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STREAM: begin
          if (hs && last) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shadow contents are don't-care outside STREAM, so no reset
  always_ff @(posedge clk) begin
    if (capture) shadow_q <= C;
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign done      = done_q;
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = valid_q && last;
  assign out_data  = valid_q ? shadow_q[row][col] : '0;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: default 4x4 build
// plus a 2x2, LATENCY=1 edge build.
module tb_matrix_result_drain;
  import matrix_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  elem_t cm   [N][N];
  elem_t expm [N][N];
  logic busy, out_last, out_valid, done;
  elem_t out_data;
  logic [IDX_W-1:0] out_row, out_col;

  logic start2 = 1'b0;
  logic ready2 = 1'b0;
  elem_t c2 [2][2];
  logic busy2, last2, valid2, done2;
  elem_t data2;
  logic [0:0] row2, col2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_result_drain u_dut (
    .clk(clk), .rst(rst), .start(start), .C(cm),
    .busy(busy), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  matrix_result_drain #(.N(2), .WIDTH(16), .LATENCY(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .C(c2),
    .busy(busy2), .out_data(data2), .out_row(row2),
    .out_col(col2), .out_last(last2),
    .out_valid(valid2), .out_ready(ready2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic elem_t val(input int mode, input int i, input int j);
    case (mode)
      0:       return elem_t'(16 * i + j);
      1:       return elem_t'(32'h100 + 16 * i + j);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic fill_c(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cm[i][j] = val(mode, i, j);
  endtask

  task automatic set_exp(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        expm[i][j] = val(mode, i, j);
  endtask

  // Entered one edge after the start edge; inj pulses start, chg swaps C
  task automatic wait_valid(input int inj, input bit chg);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      start = (cyc == inj);
      if (chg && cyc == 3) fill_c(1);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("first_valid", 64'(cyc), 64'd8);
  endtask

  task automatic start_run(input int inj, input bit chg);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(inj, chg);
  endtask

  // pat 0: ready high; pat 1: ready 1,0,0,1 repeating
  task automatic drain(input int pat, input int inj, input bit sid);
    int idx = 0;
    int c = 0;
    while (idx < N * N && c < 64) begin
      if (pat == 0) out_ready = 1'b1;
      else          out_ready = (c % 4 == 0) || (c % 4 == 3);
      start = (c == inj);
      if (out_valid) begin
        chk("data", 64'(out_data), 64'(expm[idx / N][idx % N]));
        chk("row", 64'(out_row), 64'(idx / N));
        chk("col", 64'(out_col), 64'(idx % N));
        chk("last", 64'(out_last), 64'(idx == N * N - 1));
        if (out_ready) idx++;
      end
      tick();
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("hs_count", 64'(idx), 64'(N * N));
    if (pat == 0) chk("stream_cycles", 64'(c), 64'(N * N));
    chk("done_hi", 64'(done), 64'd1);
    chk("busy_lo", 64'(busy), 64'd0);
    chk("valid_lo", 64'(out_valid), 64'd0);
    start = sid;
    tick();
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    fill_c(0);
    set_exp(0);
    c2[0][0] = 32'd1;
    c2[0][1] = 32'd2;
    c2[1][0] = 32'd3;
    c2[1][1] = 32'd4;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_row", 64'(out_row), 64'd0);
    chk("rst_col", 64'(out_col), 64'd0);
    chk("rst_valid2", 64'(valid2), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    rst = 1'b0;
    tick();

    // Basic run; C overwritten right after capture
    out_ready = 1'b1;
    start_run(-1, 1'b0);
    fill_c(2);
    drain(0, -1, 1'b0);

    // Backpressure
    fill_c(0);
    start_run(-1, 1'b0);
    drain(1, -1, 1'b0);

    // C changed during WAIT is captured, later change is not
    fill_c(0);
    set_exp(1);
    start_run(-1, 1'b1);
    fill_c(2);
    drain(0, -1, 1'b0);

    // Starts at cycles 3 and 12 ignored, start in done cycle taken
    fill_c(0);
    set_exp(0);
    start_run(3, 1'b0);
    drain(0, 4, 1'b1);
    wait_valid(-1, 1'b0);
    drain(0, -1, 1'b0);
    repeat (3) tick();
    chk("quiet_busy", 64'(busy), 64'd0);
    chk("quiet_valid", 64'(out_valid), 64'd0);

    // Reset while stalled on the 5th element
    start_run(-1, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    tick();
    chk("stall_data", 64'(out_data), 64'(expm[1][0]));
    chk("stall_row", 64'(out_row), 64'd1);
    chk("stall_col", 64'(out_col), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("srst_valid", 64'(out_valid), 64'd0);
    chk("srst_busy", 64'(busy), 64'd0);
    chk("srst_done", 64'(done), 64'd0);
    out_ready = 1'b1;
    start_run(-1, 1'b0);
    drain(0, -1, 1'b0);

    // Reset during WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_valid", 64'(out_valid), 64'd0);
    chk("wrst_busy", 64'(busy), 64'd0);
    chk("wrst_done", 64'(done), 64'd0);
    repeat (10) tick();
    chk("wrst_quiet", 64'(out_valid), 64'd0);
    start_run(-1, 1'b0);
    drain(0, -1, 1'b0);

    // 2x2, LATENCY=1 build
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1;
    while (!valid2 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("e_first_valid", 64'(cyc), 64'd2);
    for (int k = 0; k < 4; k++) begin
      chk("e_valid", 64'(valid2), 64'd1);
      chk("e_data", 64'(data2), 64'(k + 1));
      chk("e_last", 64'(last2), 64'(k == 3));
      tick();
    end
    chk("e_done", 64'(done2), 64'd1);
    chk("e_busy", 64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_result_drain.md
Name: matrix_result_drain

Overview:
- Consumer end of the matrix multiplier's result array.
- On a start pulse (issued in the same cycle the operands are presented to matrix_mult), waits the fixed multiplier latency and snapshots the full C[N][N] array into a shadow buffer.
- Then streams the elements out one per handshake, row-major, over a valid/ready interface.
- Frees the multiplier to accept a new operand set while the previous result drains.

Parameters:
- N, 4, matrix dimension (NxN); N >= 2.
- WIDTH, 16, operand bit-width; result elements are 2*WIDTH bits.
- PIPE_STAGES, 2, multiplier pipeline depth in the upstream multiplier.
- LATENCY, PIPE_STAGES+N+1 (7 at defaults), cycles from operand-valid edge to stable C; LATENCY >= 1.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: operands valid at multiplier input this cycle.
- C  input  [2*WIDTH-1:0] x [N][N]  multiplier result array.
- busy  output  1  high whenever state != IDLE.
- out_data  output  2*WIDTH  current result element.
- out_row  output  $clog2(N)  row index of out_data.
- out_col  output  $clog2(N)  column index of out_data.
- out_last  output  1  high with element (N-1,N-1).
- out_valid  output  1  element valid.
- out_ready  input  1  downstream accepts element.
- done  output  1  one-cycle pulse after final handshake.

Behaviour:
- Reset: state IDLE; out_valid, out_last, done, busy = 0; out_data, out_row, out_col = 0; wait counter and indices cleared; shadow buffer contents don't-care.
- rst overrides every other input in the same cycle, including mid-WAIT and mid-STREAM. Any in-flight result is discarded; no done pulse.
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 at edge E0 -> WAIT.
  - Wait counter loads LATENCY-1.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0 (edge E0+LATENCY), the shadow buffer loads all of C, indices reset to (0,0), and the FSM moves to STREAM.
  - LATENCY=1: capture at E0+1, i.e. one WAIT cycle.
- STREAM:
  - out_valid=1 from the cycle after capture.
  - out_data = shadow[row][col].
  - Handshake = out_valid && out_ready; col increments, wrapping to 0 with row+1.
  - While out_valid && !out_ready: out_data, out_row, out_col, out_last held stable.
  - out_last = (row==N-1 && col==N-1), combinational from the indices.
  - Handshake with out_last=1 -> IDLE, out_valid=0, done=1 for exactly the next cycle.
- Throughput: N*N elements in N*N cycles with out_ready held high. First element is valid LATENCY+1 cycles after start.
- start while busy=1 is ignored (no queueing, no error flag). start in the done cycle is accepted, since the state is already IDLE.
- C is sampled only at the capture edge; changes to C in other cycles have no effect.
- No arithmetic: elements pass through unmodified at 2*WIDTH bits.

Decomposition:
- Package matrix_pkg holds:
  - elem_t (logic [2*WIDTH-1:0]), parameterised via package parameters, or passed in.
  - Index width localparam IDX_W = $clog2(N).
  - State enum drain_state_t {IDLE, WAIT, STREAM}.
- One sub-module: matrix_idx_counter (row/col counter with enable, synchronous clear, and last flag). It is reusable by the future operand loader.
- FSM, wait counter and shadow buffer stay in the top.

Test Plan:
- Basic: C[i][j]=16*i+j, start pulse, out_ready=1.
  - Required: out_valid first high at start+LATENCY+1 (cycle 8 at defaults).
  - Required: 16 consecutive elements 0x00,0x01,...,0x33 with correct row/col.
  - Required: out_last on 0x33; done one cycle later; busy falls with done.
- Backpressure: same C, out_ready toggles 1,0,0,1 repeating.
  - Required: no element dropped or duplicated; out_data/out_row/out_col stable across every stalled cycle; total 16 handshakes.
- Snapshot isolation: after capture, bench drives C to all 0xFFFFFFFF.
  - Required: streamed values remain 16*i+j.
  - Required: changing C during WAIT before the capture edge alters the output; changes after it do not.
- Start while busy: second start at cycles 3 and 12 after the first.
  - Required: both ignored; exactly 16 elements and one done.
  - Required: start in the done cycle launches a new run with first valid LATENCY+1 cycles later.
- Reset mid-operation: rst at the 5th stalled element, and separately during WAIT.
  - Required: next cycle out_valid=0, busy=0, done=0.
  - Required: a subsequent start streams from (0,0).
- Edge config: N=2, LATENCY=1, C={{1,2},{3,4}}.
  - Required: first valid at start+2; sequence 1,2,3,4; out_last on 4.
